// File: rtl/dmem_arbiter_pkg.sv
// Shared codes and types for the data-memory arbiter.
// Holds the memory access-kind codes (load/store selects, write-enable level),
// the arbiter FSM states and port ids, the latched-request struct and a helper
// that maps an access kind to its size in bytes.
package dmem_arbiter_pkg;

  // Load kinds understood by the data memory.
  localparam logic [2:0] LOAD_SEL_B    = 3'd0;
  localparam logic [2:0] LOAD_SEL_BU   = 3'd1;
  localparam logic [2:0] LOAD_SEL_H    = 3'd2;
  localparam logic [2:0] LOAD_SEL_HU   = 3'd3;
  localparam logic [2:0] LOAD_SEL_W    = 3'd4;
  // Not a load kind; the memory returns 0 for it.
  localparam logic [2:0] LOAD_SEL_NONE = 3'd7;

  // Store kinds understood by the data memory.
  localparam logic [1:0] STORE_SEL_B = 2'd0;
  localparam logic [1:0] STORE_SEL_H = 2'd1;
  localparam logic [1:0] STORE_SEL_W = 2'd2;

  // Level of wr_en that commits a store.
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic {
    ARB_ST_IDLE,
    ARB_ST_ACCESS
  } arb_state_e;

  typedef enum logic {
    ARB_PORT_CORE,
    ARB_PORT_DMA
  } arb_port_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  load_sel;
    logic [1:0]  store_sel;
  } arb_req_t;

  // Access size in bytes (1/2/4); 0 marks an invalid select code.
  function automatic logic [2:0] access_size(input logic       we,
                                             input logic [2:0] load_sel,
                                             input logic [1:0] store_sel);
    logic [2:0] size;
    size = 3'd0;
    if (we) begin
      case (store_sel)
        STORE_SEL_B: size = 3'd1;
        STORE_SEL_H: size = 3'd2;
        STORE_SEL_W: size = 3'd4;
        default:     size = 3'd0;
      endcase
    end else begin
      case (load_sel)
        LOAD_SEL_B, LOAD_SEL_BU: size = 3'd1;
        LOAD_SEL_H, LOAD_SEL_HU: size = 3'd2;
        LOAD_SEL_W:              size = 3'd4;
        default:                 size = 3'd0;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/acknowledge bundle for one requester of the data-memory arbiter.
// master: the requester (drives req and operands, receives gnt/ack/err/rdata).
// slave:  the arbiter side.
//   req       access request, held with stable operands until gnt
//   we        1 = store, 0 = load
//   addr      byte address
//   wdata     store data
//   load_sel  load kind
//   store_sel store kind
//   gnt       combinational accept
//   ack       registered one-cycle completion pulse
//   err       valid with ack, 1 = access rejected
//   rdata     load result, updated on ack
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  load_sel;
  logic [1:0]  store_sel;
  logic        gnt;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, load_sel, store_sel,
    input  gnt, ack, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata, load_sel, store_sel,
    output gnt, ack, err, rdata
  );
endinterface

// File: rtl/dmem_req_check.sv
// Combinational legality check for one memory access.
// Flags invalid select codes, misaligned halfword/word accesses and accesses
// that would run past the end of a MEM_NBYTE-byte memory.
//   i_we        1 = store, 0 = load
//   i_addr      byte address
//   i_load_sel  load kind
//   i_store_sel store kind
//   o_err       1 = access must be rejected
module dmem_req_check
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_NBYTE = 1024
) (
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_load_sel,
  input  logic [1:0]  i_store_sel,
  output logic        o_err
);

  localparam logic [31:0] NByte = MEM_NBYTE;

  logic [2:0] w_size;
  logic       w_sel_bad;
  logic       w_misalign;
  logic       w_oor;

  assign w_size     = access_size(i_we, i_load_sel, i_store_sel);
  assign w_sel_bad  = (w_size == 3'd0);
  assign w_misalign = ((w_size == 3'd2) && i_addr[0]) ||
                      ((w_size == 3'd4) && (i_addr[1:0] != 2'b00));
  // Unsigned compare, so addresses near 2^32 are rejected rather than wrapping.
  assign w_oor      = (i_addr > (NByte - {29'd0, w_size}));
  assign o_err      = w_sel_bad || w_misalign || w_oor;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port byte-addressed data memory.
// Shares the memory between the core LSU (c) and a debug/DMA master (d),
// arbitrating round-robin (RR_EN=1) or core-first (RR_EN=0). Each access takes
// an IDLE (grant) cycle and an ACCESS (memory) cycle; completion is reported
// one cycle later through registered ack/err/rdata on the granted port.
//   clk, rst_n    clock, asynchronous active-low reset
//   c, d          requester bundles (slave side)
//   m_addr        memory byte address
//   m_dataW       memory store data
//   m_load_sel    memory load kind (invalid code outside loads)
//   m_store_sel   memory store kind
//   m_wr_en       memory write enable, MEM_WRITE commits
//   m_dataR       memory read data (combinational)
//   busy          1 while in ACCESS
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_NBYTE = 1024,
  parameter bit          RR_EN     = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave c,
  dmem_arbiter_if.slave d,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_dataW,
  output logic [2:0]    m_load_sel,
  output logic [1:0]    m_store_sel,
  output logic          m_wr_en,
  input  logic [31:0]   m_dataR,
  output logic          busy
);

  arb_state_e  r_state;
  arb_port_e   r_turn;
  arb_port_e   r_port;
  arb_req_t    r_op;
  logic        r_err;
  logic        r_c_ack;
  logic        r_c_err;
  logic [31:0] r_c_rdata;
  logic        r_d_ack;
  logic        r_d_err;
  logic [31:0] r_d_rdata;

  logic        w_idle;
  logic        w_c_win;
  logic        w_d_win;
  logic        w_c_gnt;
  logic        w_d_gnt;
  logic        w_chk_err;
  logic [31:0] w_rdata;
  arb_req_t    w_c_op;
  arb_req_t    w_d_op;
  arb_req_t    w_sel_op;

  assign w_c_op = '{we: c.we, addr: c.addr, wdata: c.wdata,
                    load_sel: c.load_sel, store_sel: c.store_sel};
  assign w_d_op = '{we: d.we, addr: d.addr, wdata: d.wdata,
                    load_sel: d.load_sel, store_sel: d.store_sel};

  // rst_n gates the grant so nothing is accepted while reset is asserted.
  assign w_idle  = (r_state == ARB_ST_IDLE) && rst_n;
  assign w_c_win = c.req && (!RR_EN || !d.req || (r_turn == ARB_PORT_CORE));
  assign w_d_win = d.req && !w_c_win;
  assign w_c_gnt = w_idle && w_c_win;
  assign w_d_gnt = w_idle && w_d_win;

  assign w_sel_op = w_d_win ? w_d_op : w_c_op;

  dmem_req_check #(
    .MEM_NBYTE(MEM_NBYTE)
  ) u_check (
    .i_we       (w_sel_op.we),
    .i_addr     (w_sel_op.addr),
    .i_load_sel (w_sel_op.load_sel),
    .i_store_sel(w_sel_op.store_sel),
    .o_err      (w_chk_err)
  );

  // Stores and rejected accesses return zero read data.
  assign w_rdata = (r_err || r_op.we) ? 32'd0 : m_dataR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_ST_IDLE;
      r_turn    <= ARB_PORT_CORE;
      r_port    <= ARB_PORT_CORE;
      r_op      <= '0;
      r_err     <= 1'b0;
      r_c_ack   <= 1'b0;
      r_c_err   <= 1'b0;
      r_c_rdata <= 32'd0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= 32'd0;
    end else begin
      r_c_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        ARB_ST_IDLE: begin
          if (w_c_gnt || w_d_gnt) begin
            r_state <= ARB_ST_ACCESS;
            r_op    <= w_sel_op;
            r_err   <= w_chk_err;
            r_port  <= w_d_gnt ? ARB_PORT_DMA : ARB_PORT_CORE;
            r_turn  <= w_d_gnt ? ARB_PORT_CORE : ARB_PORT_DMA;
          end
        end
        ARB_ST_ACCESS: begin
          r_state <= ARB_ST_IDLE;
          if (r_port == ARB_PORT_CORE) begin
            r_c_ack   <= 1'b1;
            r_c_err   <= r_err;
            r_c_rdata <= w_rdata;
          end else begin
            r_d_ack   <= 1'b1;
            r_d_err   <= r_err;
            r_d_rdata <= w_rdata;
          end
        end
      endcase
    end
  end

  always_comb begin
    m_addr      = 32'd0;
    m_dataW     = 32'd0;
    m_load_sel  = LOAD_SEL_NONE;
    m_store_sel = 2'd0;
    m_wr_en     = ~MEM_WRITE;
    if (r_state == ARB_ST_ACCESS) begin
      m_addr      = r_op.addr;
      m_dataW     = r_op.wdata;
      m_store_sel = r_op.store_sel;
      if (!r_err) begin
        if (r_op.we) begin
          m_wr_en = MEM_WRITE;
        end else begin
          m_load_sel = r_op.load_sel;
        end
      end
    end
  end

  assign busy    = (r_state == ARB_ST_ACCESS);
  assign c.gnt   = w_c_gnt;
  assign d.gnt   = w_d_gnt;
  assign c.ack   = r_c_ack;
  assign c.err   = r_c_err;
  assign c.rdata = r_c_rdata;
  assign d.ack   = r_d_ack;
  assign d.err   = r_d_err;
  assign d.rdata = r_d_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a small
// byte memory model, plus a fixed-priority instance used for grant ordering.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned MemNbyte = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if c_if ();
  dmem_arbiter_if d_if ();
  dmem_arbiter_if cf_if ();
  dmem_arbiter_if df_if ();

  logic [31:0] m_addr, m_dataW, m_dataR;
  logic [2:0]  m_load_sel;
  logic [1:0]  m_store_sel;
  logic        m_wr_en, busy;

  logic [31:0] fm_addr, fm_dataW, fm_dataR;
  logic [2:0]  fm_load_sel;
  logic [1:0]  fm_store_sel;
  logic        fm_wr_en, fbusy;
  assign fm_dataR = 32'd0;

  dmem_arbiter #(.MEM_NBYTE(MemNbyte), .RR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .c(c_if), .d(d_if),
    .m_addr(m_addr), .m_dataW(m_dataW), .m_load_sel(m_load_sel),
    .m_store_sel(m_store_sel), .m_wr_en(m_wr_en), .m_dataR(m_dataR), .busy(busy)
  );

  dmem_arbiter #(.MEM_NBYTE(MemNbyte), .RR_EN(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .c(cf_if), .d(df_if),
    .m_addr(fm_addr), .m_dataW(fm_dataW), .m_load_sel(fm_load_sel),
    .m_store_sel(fm_store_sel), .m_wr_en(fm_wr_en), .m_dataR(fm_dataR), .busy(fbusy)
  );

  // Byte memory model: combinational read, store on the rising edge.
  logic [7:0]  mem [MemNbyte] = '{default: 8'h00};
  logic [31:0] a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  assign a1 = m_addr + 32'd1;
  assign a2 = m_addr + 32'd2;
  assign a3 = m_addr + 32'd3;
  assign b0 = (m_addr < MemNbyte) ? mem[m_addr[9:0]] : 8'h00;
  assign b1 = (a1 < MemNbyte) ? mem[a1[9:0]] : 8'h00;
  assign b2 = (a2 < MemNbyte) ? mem[a2[9:0]] : 8'h00;
  assign b3 = (a3 < MemNbyte) ? mem[a3[9:0]] : 8'h00;

  always_comb begin
    m_dataR = 32'd0;
    case (m_load_sel)
      LOAD_SEL_B:  m_dataR = {{24{b0[7]}}, b0};
      LOAD_SEL_BU: m_dataR = {24'h0, b0};
      LOAD_SEL_H:  m_dataR = {{16{b1[7]}}, b1, b0};
      LOAD_SEL_HU: m_dataR = {16'h0, b1, b0};
      LOAD_SEL_W:  m_dataR = {b3, b2, b1, b0};
      default:     m_dataR = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (m_wr_en == MEM_WRITE) begin
      case (m_store_sel)
        STORE_SEL_B: mem[m_addr[9:0]] <= m_dataW[7:0];
        STORE_SEL_H: begin
          mem[m_addr[9:0]] <= m_dataW[7:0];
          mem[a1[9:0]]     <= m_dataW[15:8];
        end
        STORE_SEL_W: begin
          mem[m_addr[9:0]] <= m_dataW[7:0];
          mem[a1[9:0]]     <= m_dataW[15:8];
          mem[a2[9:0]]     <= m_dataW[23:16];
          mem[a3[9:0]]     <= m_dataW[31:24];
        end
        default: ;
      endcase
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // sel: 0 = c_if, 1 = d_if, 2 = cf_if, 3 = df_if
  task automatic set_port(input int sel, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] lsel, input logic [1:0] ssel);
    case (sel)
      0: begin
        c_if.req = req; c_if.we = we; c_if.addr = addr; c_if.wdata = wdata;
        c_if.load_sel = lsel; c_if.store_sel = ssel;
      end
      1: begin
        d_if.req = req; d_if.we = we; d_if.addr = addr; d_if.wdata = wdata;
        d_if.load_sel = lsel; d_if.store_sel = ssel;
      end
      2: begin
        cf_if.req = req; cf_if.we = we; cf_if.addr = addr; cf_if.wdata = wdata;
        cf_if.load_sel = lsel; cf_if.store_sel = ssel;
      end
      default: begin
        df_if.req = req; df_if.we = we; df_if.addr = addr; df_if.wdata = wdata;
        df_if.load_sel = lsel; df_if.store_sel = ssel;
      end
    endcase
  endtask

  // One complete access on the RR instance: grant now, ACCESS next, ack after.
  task automatic txn(input string tag, input bit dma, input logic we,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] lsel, input logic [1:0] ssel,
                     input logic exp_err, input logic [31:0] exp_rdata);
    logic wr_exp;
    wr_exp = (we && !exp_err) ? MEM_WRITE : ~MEM_WRITE;
    @(negedge clk);
    set_port(dma ? 1 : 0, 1'b1, we, addr, wdata, lsel, ssel);
    #1;
    check({tag, " gnt"}, {31'd0, (dma ? d_if.gnt : c_if.gnt)}, 32'd1);
    check({tag, " other gnt"}, {31'd0, (dma ? c_if.gnt : d_if.gnt)}, 32'd0);
    @(negedge clk);
    if (dma) d_if.req = 1'b0;
    else c_if.req = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    check({tag, " m_wr_en"}, {31'd0, m_wr_en}, {31'd0, wr_exp});
    check({tag, " m_addr"}, m_addr, addr);
    @(negedge clk);
    check({tag, " ack"}, {31'd0, (dma ? d_if.ack : c_if.ack)}, 32'd1);
    check({tag, " err"}, {31'd0, (dma ? d_if.err : c_if.err)}, {31'd0, exp_err});
    if (!we || exp_err) check({tag, " rdata"}, (dma ? d_if.rdata : c_if.rdata), exp_rdata);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  logic [1:0] exp_g;

  initial begin
    for (int s = 0; s < 4; s++) set_port(s, 1'b0, 1'b0, 32'd0, 32'd0, LOAD_SEL_W, STORE_SEL_W);
    c_if.req = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("reset c_gnt", {31'd0, c_if.gnt}, 32'd0);
    check("reset c_ack", {31'd0, c_if.ack}, 32'd0);
    check("reset d_ack", {31'd0, d_if.ack}, 32'd0);
    check("reset c_rdata", c_if.rdata, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset m_wr_en", {31'd0, m_wr_en}, {31'd0, ~MEM_WRITE});
    check("reset m_load_sel", {29'd0, m_load_sel}, {29'd0, LOAD_SEL_NONE});
    check("reset m_addr", m_addr, 32'd0);
    c_if.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    txn("c st W", 0, 1'b1, 32'h10, 32'hDEADBEEF, LOAD_SEL_W, STORE_SEL_W, 1'b0, 32'd0);
    check("mem 0x10", {mem[19], mem[18], mem[17], mem[16]}, 32'hDEADBEEF);
    txn("c ld W", 0, 1'b0, 32'h10, 32'd0, LOAD_SEL_W, STORE_SEL_W, 1'b0, 32'hDEADBEEF);
    txn("d ld H mis", 1, 1'b0, 32'h3, 32'd0, LOAD_SEL_H, STORE_SEL_W, 1'b1, 32'd0);
    txn("d st H top", 1, 1'b1, 32'd1022, 32'h0000A55A, LOAD_SEL_W, STORE_SEL_H, 1'b0, 32'd0);
    txn("c st W oor", 0, 1'b1, 32'd1022, 32'h12345678, LOAD_SEL_W, STORE_SEL_W, 1'b1, 32'd0);
    check("mem top unchanged", {16'h0, mem[1023], mem[1022]}, 32'h0000A55A);
    txn("c ld BU top", 0, 1'b0, 32'd1023, 32'd0, LOAD_SEL_BU, STORE_SEL_W, 1'b0, 32'h000000A5);
    txn("c ld W 1020", 0, 1'b0, 32'd1020, 32'd0, LOAD_SEL_W, STORE_SEL_W, 1'b0, 32'hA55A0000);
    txn("c ld W wrap", 0, 1'b0, 32'hFFFFFFFC, 32'd0, LOAD_SEL_W, STORE_SEL_W, 1'b1, 32'd0);
    txn("d ld bad sel", 1, 1'b0, 32'h10, 32'd0, 3'd5, STORE_SEL_W, 1'b1, 32'd0);
    txn("d st bad sel", 1, 1'b1, 32'h10, 32'd0, LOAD_SEL_W, 2'd3, 1'b1, 32'd0);
    txn("d st B", 1, 1'b1, 32'h20, 32'h00000080, LOAD_SEL_W, STORE_SEL_B, 1'b0, 32'd0);
    txn("d ld B", 1, 1'b0, 32'h20, 32'd0, LOAD_SEL_B, STORE_SEL_W, 1'b0, 32'hFFFFFF80);
    txn("d ld BU", 1, 1'b0, 32'h20, 32'd0, LOAD_SEL_BU, STORE_SEL_W, 1'b0, 32'h00000080);

    // Both ports held: RR instance alternates from core, fixed one stays on core.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 32'h10, 32'd0, LOAD_SEL_W, STORE_SEL_W);
    set_port(1, 1'b1, 1'b0, 32'h20, 32'd0, LOAD_SEL_W, STORE_SEL_W);
    set_port(2, 1'b1, 1'b0, 32'h10, 32'd0, LOAD_SEL_W, STORE_SEL_W);
    set_port(3, 1'b1, 1'b0, 32'h20, 32'd0, LOAD_SEL_W, STORE_SEL_W);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (i % 2 == 1) exp_g = 2'b00;
      else exp_g = ((i / 2) % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("rr gnt cyc %0d", i), {30'd0, c_if.gnt, d_if.gnt}, {30'd0, exp_g});
      exp_g = (i % 2 == 1) ? 2'b00 : 2'b10;
      check($sformatf("fix gnt cyc %0d", i), {30'd0, cf_if.gnt, df_if.gnt}, {30'd0, exp_g});
    end
    c_if.req = 1'b0;
    d_if.req = 1'b0;
    cf_if.req = 1'b0;
    @(negedge clk);
    #1;
    check("rr last d_ack", {31'd0, d_if.ack}, 32'd1);
    check("rr last d_rdata", d_if.rdata, 32'h00000080);
    check("rr c_rdata held", c_if.rdata, 32'hDEADBEEF);
    check("fix d gnt after c drop", {30'd0, cf_if.gnt, df_if.gnt}, 32'd1);
    @(negedge clk);
    df_if.req = 1'b0;

    // Reset during the ACCESS cycle of a store.
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 32'h40, 32'h11223344, LOAD_SEL_W, STORE_SEL_W);
    #1;
    check("rst st gnt", {31'd0, c_if.gnt}, 32'd1);
    @(negedge clk);
    c_if.req = 1'b0;
    check("rst st busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst mid busy", {31'd0, busy}, 32'd0);
    check("rst mid m_wr_en", {31'd0, m_wr_en}, {31'd0, ~MEM_WRITE});
    check("rst mid c_rdata", c_if.rdata, 32'd0);
    check("rst mid d_rdata", d_if.rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst no commit", {mem[67], mem[66], mem[65], mem[64]}, 32'd0);
    check("rst no ack 1", {31'd0, c_if.ack}, 32'd0);
    @(negedge clk);
    #1;
    check("rst no ack 2", {31'd0, c_if.ack}, 32'd0);
    set_port(0, 1'b1, 1'b0, 32'h10, 32'd0, LOAD_SEL_W, STORE_SEL_W);
    set_port(1, 1'b1, 1'b0, 32'h20, 32'd0, LOAD_SEL_W, STORE_SEL_W);
    #1;
    check("post rst tie", {30'd0, c_if.gnt, d_if.gnt}, 32'd2);
    @(negedge clk);
    c_if.req = 1'b0;
    d_if.req = 1'b0;
    @(negedge clk);
    #1;
    check("post rst c_ack", {31'd0, c_if.ack}, 32'd1);
    check("post rst c_rdata", c_if.rdata, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port access controller in front of the byte-addressed data memory. It shares the single memory port between the core load/store unit (port `c_`) and a debug/DMA master (port `d_`). It arbitrates with round-robin or fixed priority, checks alignment and range, and sequences each access through a two-state FSM. Read data and the completion status are returned through registered per-port acknowledge signals.

## Interface
Parameters:
- `MEM_NBYTE`, 1024: memory size in bytes. Must match the memory instance.
- `RR_EN`, 1: 1 = round-robin between ports; 0 = fixed priority, core always wins.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous and active-low.
- `c_req` / `d_req`  in  1  access request. Held with stable operands until `*_gnt`.
- `c_we` / `d_we`  in  1  1 = store, 0 = load.
- `c_addr` / `d_addr`  in  32  byte address.
- `c_wdata` / `d_wdata`  in  32  store data; size is selected by `*_store_sel`.
- `c_load_sel` / `d_load_sel`  in  3  load kind: `LOAD_SEL_B`, `LOAD_SEL_BU`, `LOAD_SEL_H`, `LOAD_SEL_HU` or `LOAD_SEL_W`.
- `c_store_sel` / `d_store_sel`  in  2  store kind: `STORE_SEL_B`, `STORE_SEL_H` or `STORE_SEL_W`.
- `c_gnt` / `d_gnt`  out  1  combinational. Request accepted this cycle.
- `c_ack` / `d_ack`  out  1  registered one-cycle completion pulse.
- `c_err` / `d_err`  out  1  valid with `*_ack`. 1 = access rejected.
- `c_rdata` / `d_rdata`  out  32  load result. Updated only on that port's `*_ack`, held otherwise.
- `m_addr`  out  32  to memory `addr`.
- `m_dataW`  out  32  to memory `dataW`.
- `m_load_sel`  out  3  to memory `load_sel`.
- `m_store_sel`  out  2  to memory `store_sel`.
- `m_wr_en`  out  1  to memory `wr_en`. Active value is `MEM_WRITE`.
- `m_dataR`  in  32  from memory `dataR`. Combinational.
- `busy`  out  1  1 while the FSM is in ACCESS.

## Operation
FSM states:
- **IDLE**
  - Arbitrate among the asserted requests and assert exactly one `*_gnt`.
  - Latch that port's operands, the port id and the error check result.
  - Go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS**
  - Drive `m_*` from the latched operands.
  - Capture `m_dataR` for loads.
  - Go to IDLE.

Arbitration:
- `RR_EN=1`
  - A single requester wins.
  - On a tie, the port named by the `turn` pointer wins.
  - `turn` flips to the other port after every grant.
  - Reset value of `turn` is core.
- `RR_EN=0`: core wins every tie; DMA is granted only when `c_req` is 0.

Error check, done on the granted operands at grant time:
- Store with `store_sel` not B/H/W.
- Load with `load_sel` not one of the five valid codes.
- Misalignment: H with `addr[0]` set; W with `addr[1:0]` nonzero.
- Out of range: `addr > MEM_NBYTE - size`, with size 1/2/4. The compare is unsigned 32-bit.

Error handling:
- An erroring access still occupies an ACCESS cycle.
- `m_wr_en` is held inactive during that cycle.
- The port receives `*_err=1` and `*_rdata` = 0.

Default outputs outside ACCESS:
- `m_wr_en` inactive.
- `m_addr` and `m_dataW` = 0.
- `m_load_sel` = an invalid code, so the memory returns 0.
- `m_store_sel` = 0.

## Timing
- Cycle N, IDLE, `c_req`=1: `c_gnt`=1 in cycle N. Operands are sampled at the end of N.
- Cycle N+1, ACCESS: `m_*` are valid. A store commits at the rising edge ending N+1.
- Cycle N+2:
  - `c_ack`=1 for exactly one cycle, with `c_rdata` and `c_err` valid.
  - The FSM is back in IDLE and may grant again in N+2.
  - Throughput is one access per 2 cycles.
- A requester may drop `req`, or present a new request, from cycle N+1.
- A request asserted during ACCESS waits for the next IDLE cycle.
- A store followed by a load to the same address reads the new data, because the store has committed before the load's ACCESS cycle.
- Reset behaviour:
  - Asynchronous reset at any time forces IDLE, `turn`=core and all `*_ack`, `*_err`, `*_rdata` = 0.
  - All `m_*` outputs take their defaults and `busy`=0.
  - An in-flight access is dropped with no ack.
  - `*_gnt` is 0 while `rst_n` is 0.

## Structure
- Shared macro header `0_macro.v` holds:
  - the existing `LOAD_SEL_*`, `STORE_SEL_*` and `MEM_WRITE` codes;
  - new `ARB_ST_IDLE` / `ARB_ST_ACCESS`;
  - new `ARB_PORT_CORE` / `ARB_PORT_DMA`.
- One sub-module, `dmem_req_check`: combinational validity, alignment and range check, parameterised by `MEM_NBYTE`. It is instantiated once on the muxed operands.

## Test plan
- Core stores W 0xDEADBEEF @0x10, then loads W @0x10 → first `c_ack` has err=0. Second `c_ack` arrives 2 cycles after its grant with `c_rdata`=0xDEADBEEF.
- `c_req` and `d_req` held high for 6 grants, `RR_EN=1` → grants alternate C,D,C,D,C,D on cycles 0,2,4,…. With `RR_EN=0` → all grants go to C while `c_req` is held.
- DMA loads H @0x3 → `d_ack` with err=1, rdata=0. `m_wr_en` is never active.
- Core stores W @`MEM_NBYTE-2` → err=1 and memory is unchanged. Load BU @`MEM_NBYTE-1` → err=0.
- DMA stores B 0x80 @0x20, then loads B and BU @0x20 → rdata 0xFFFFFF80 and 0x00000080.
- `rst_n` pulsed low during ACCESS of a store → no ack, FSM in IDLE, `m_wr_en` inactive, `turn`=core. The next tie grants core.
